// File: rtl/jtag_mem_responder_pkg.sv
// Shared types and default widths for the JTAG debug memory responder.
// Holds the FSM state enum, the latched command record and default widths.
package jtag_mem_pkg;

   localparam int JM_AW = 32;
   localparam int JM_DW = 64;
   localparam int JM_LW = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      RESP   = 2'd3
   } jtag_mem_state_t;

   typedef struct packed {
      logic             we;
      logic [JM_AW-1:0] addr;
      logic [JM_DW-1:0] wdata;
      logic [JM_LW-1:0] len;
      logic             inc;
   } jtag_mem_cmd_t;

endpackage

// File: rtl/jtag_mem_responder_if.sv
// Single-outstanding req/gnt/rvalid memory port.
// The master modport is the responder side; the slave modport is the memory side.
interface jtag_mem_responder_if #(
   parameter int AW = 32,
   parameter int DW = 64
);
   logic          req;
   logic          gnt;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW/8-1:0] be;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, addr, wdata, be,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/jtag_mem_responder_timeout.sv
// Per-beat abort timer for the memory responder.
// Reloads while cleared and counts down while enabled. It flags expiry on the
// CYCLES-th consecutive enabled cycle.
// This module is only instantiated when JTAG_MEM_TIMEOUT_EN is defined.
module jtag_mem_timeout #(
   parameter int CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] cnt_q;

   // Reload on clear, count down while the beat is outstanding
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= CW'(CYCLES);
      end else if (enable_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign expired_o = enable_i && (cnt_q == CW'(1));
endmodule

// File: rtl/jtag_mem_responder.sv
// Memory-side responder for the JTAG debug memory-access path.
// It runs one command (read, or write fill) as a burst of single-outstanding
// memory beats. It returns one response beat per memory beat.
// Optional feature: `define JTAG_MEM_TIMEOUT_EN enables a per-beat abort timer.
// On expiry the timer returns one error beat and abandons the rest of the burst.
module jtag_mem_responder
   import jtag_mem_pkg::*;
#(
   parameter int AW = JM_AW,
   parameter int DW = JM_DW,
   parameter int LW = JM_LW,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_we_i,
   input  logic [AW-1:0] cmd_addr_i,
   input  logic [DW-1:0] cmd_wdata_i,
   input  logic [LW-1:0] cmd_len_i,
   input  logic          cmd_inc_i,
   output logic          rsp_valid_o,
   input  logic          rsp_ready_i,
   output logic [DW-1:0] rsp_rdata_o,
   output logic          rsp_err_o,
   output logic          rsp_last_o,
   jtag_mem_responder_if.master mem,
   output logic          busy_o
);
   localparam logic [AW-1:0] STEP       = AW'(DW / 8);
   localparam logic [AW-1:0] ALIGN_MASK = AW'(DW / 8 - 1);

   jtag_mem_state_t state_q, state_d;

   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [LW-1:0] cnt_q;
   logic          inc_q;
   logic [DW-1:0] rdata_q;
   logic          err_q;
   logic          timeout_hit;
   logic          timeout_abort;
   logic          beat_active;

   assign beat_active = (state_q == REQ) || (state_q == WAIT_R);

`ifdef JTAG_MEM_TIMEOUT_EN
   jtag_mem_timeout #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (!beat_active),
      .enable_i  (beat_active),
      .expired_o (timeout_hit)
   );

   // Error flag: cleared by each new command and set when a beat is abandoned
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if ((state_q == IDLE) && cmd_valid_i) begin
         err_q <= 1'b0;
      end else if (timeout_abort) begin
         err_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err_q       = 1'b0;
`endif

   // An arriving gnt or rvalid wins over an expiry in the same cycle
   assign timeout_abort = timeout_hit &&
                          (((state_q == REQ) && !mem.gnt) ||
                           ((state_q == WAIT_R) && !mem.rvalid));

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) state_d = REQ;
         end
         REQ: begin
            if (mem.gnt)          state_d = WAIT_R;
            else if (timeout_hit) state_d = RESP;
         end
         WAIT_R: begin
            if (mem.rvalid)       state_d = RESP;
            else if (timeout_hit) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = ((cnt_q == '0) || err_q) ? IDLE : REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      cmd_ready_o = (state_q == IDLE);
      busy_o      = (state_q != IDLE);
      mem.req     = (state_q == REQ);
      rsp_valid_o = (state_q == RESP);
      rsp_last_o  = (state_q == RESP) && ((cnt_q == '0) || err_q);
      rsp_err_o   = (state_q == RESP) && err_q;
   end

   assign mem.we      = we_q;
   assign mem.addr    = addr_q;
   assign mem.wdata   = wdata_q;
   assign mem.be      = '1;
   assign rsp_rdata_o = rdata_q;

   // Command latch, per-beat address/count advance and response data capture
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         inc_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if ((state_q == IDLE) && cmd_valid_i) begin
            we_q    <= cmd_we_i;
            addr_q  <= cmd_addr_i & ~ALIGN_MASK;
            wdata_q <= cmd_wdata_i;
            cnt_q   <= cmd_len_i;
            inc_q   <= cmd_inc_i;
         end
         if ((state_q == WAIT_R) && mem.rvalid) begin
            rdata_q <= we_q ? '0 : mem.rdata;
         end
         if (timeout_abort) begin
            rdata_q <= '0;
         end
         // Counter only moves when more beats remain, so it never underflows
         if ((state_q == RESP) && rsp_ready_i && (cnt_q != '0) && !err_q) begin
            cnt_q <= cnt_q - LW'(1);
            if (inc_q) addr_q <= addr_q + STEP;
         end
      end
   end
endmodule

// File: tb/tb_jtag_mem_responder.sv
// Testbench for jtag_mem_responder. It applies a table of directed burst
// vectors, then runs hand-written sequences for reset mid-burst and, when
// JTAG_MEM_TIMEOUT_EN is defined, for the abort timer.
module tb_jtag_mem_responder;
   import jtag_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_we, cmd_inc;
   logic [31:0] cmd_addr;
   logic [63:0] cmd_wdata;
   logic [7:0]  cmd_len;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
   logic [63:0] rsp_rdata;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   jtag_mem_responder_if #(.AW(32), .DW(64)) mem_bus ();

   jtag_mem_responder #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_addr_i  (cmd_addr),
      .cmd_wdata_i (cmd_wdata),
      .cmd_len_i   (cmd_len),
      .cmd_inc_i   (cmd_inc),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .rsp_last_o  (rsp_last),
      .mem         (mem_bus.master),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   typedef struct {
      jtag_mem_cmd_t cmd;
      int            gnt_dly;
      int            rv_dly;
      int            rdy_dly;
      logic          spur_rv;
      logic [63:0]   rbase;
      logic [31:0]   exp_first;
      logic [31:0]   exp_last;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [31:0] addr,
                               input logic [63:0] wd, input int len, input logic inc,
                               input int g, input int r, input int rd, input logic sp,
                               input logic [63:0] rb, input logic [31:0] f,
                               input logic [31:0] l);
      vec_t v;
      v.cmd.we    = we;
      v.cmd.addr  = addr;
      v.cmd.wdata = wd;
      v.cmd.len   = 8'(len);
      v.cmd.inc   = inc;
      v.gnt_dly   = g;
      v.rv_dly    = r;
      v.rdy_dly   = rd;
      v.spur_rv   = sp;
      v.rbase     = rb;
      v.exp_first = f;
      v.exp_last  = l;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic issue(input jtag_mem_cmd_t c);
      @(negedge clk);
      cmd_we    = c.we;
      cmd_addr  = c.addr;
      cmd_wdata = c.wdata;
      cmd_len   = c.len;
      cmd_inc   = c.inc;
      cmd_valid = 1'b1;
      chk("cmd_ready_idle", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("cmd_ready_busy", cmd_ready, 0);
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (mem_bus.req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL req_wait: no mem req within 50 cycles");
      end
   endtask

   task automatic do_beat(input vec_t v, input int b, output bit ok);
      logic [31:0] ea;
      logic [63:0] ed;
      ea = (v.cmd.addr & 32'hFFFF_FFF8) + (v.cmd.inc ? 32'(b) * 32'd8 : 32'd0);
      ed = v.cmd.we ? 64'd0 : v.rbase + 64'(b);
      wait_req(ok);
      if (!ok) return;
      chk("mem_addr", mem_bus.addr, ea);
      chk("mem_we", mem_bus.we, v.cmd.we);
      chk("mem_be", mem_bus.be, 64'hFF);
      if (v.cmd.we) chk("mem_wdata", mem_bus.wdata, v.cmd.wdata);
      if (b == 0) chk("addr_first", mem_bus.addr, v.exp_first);
      if (b == int'(v.cmd.len)) chk("addr_last", mem_bus.addr, v.exp_last);
      for (int g = 0; g < v.gnt_dly; g++) begin
         if (v.spur_rv && g == 0) begin
            mem_bus.rvalid = 1'b1;
            mem_bus.rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
         end
         @(negedge clk);
         mem_bus.rvalid = 1'b0;
         chk("req_held_stall", mem_bus.req, 1);
         chk("addr_held_stall", mem_bus.addr, ea);
      end
      mem_bus.gnt = 1'b1;
      @(negedge clk);
      mem_bus.gnt = 1'b0;
      chk("req_dropped_after_gnt", mem_bus.req, 0);
      repeat (v.rv_dly) @(negedge clk);
      mem_bus.rvalid = 1'b1;
      mem_bus.rdata  = v.rbase + 64'(b);
      @(negedge clk);
      mem_bus.rvalid = 1'b0;
      mem_bus.rdata  = 64'h5555_AAAA_5555_AAAA;
      chk("rsp_valid", rsp_valid, 1);
      for (int r = 0; r < v.rdy_dly; r++) begin
         @(negedge clk);
         chk("rsp_held_bp", rsp_valid, 1);
         chk("rdata_held_bp", rsp_rdata, ed);
         chk("no_req_during_bp", mem_bus.req, 0);
      end
      chk("rsp_rdata", rsp_rdata, ed);
      chk("rsp_last", rsp_last, (b == int'(v.cmd.len)) ? 1 : 0);
      chk("rsp_err", rsp_err, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      bit ok;
      issue(v.cmd);
      for (int b = 0; b <= int'(v.cmd.len); b++) begin
         do_beat(v, b, ok);
         if (!ok) return;
      end
      chk("busy_done", busy, 0);
      chk("cmd_ready_done", cmd_ready, 1);
      chk("rsp_valid_done", rsp_valid, 0);
   endtask

   vec_t vecs[8];

   initial begin
      bit ok;
      vec_t rv;
      vecs[0] = mk(1'b0, 32'h8000_0000, 64'h0, 0, 1'b1, 0, 1, 0, 1'b0,
                   64'hDEAD_BEEF_CAFE_F00D, 32'h8000_0000, 32'h8000_0000);
      vecs[1] = mk(1'b1, 32'h0000_1000, 64'h11, 3, 1'b1, 0, 0, 0, 1'b0,
                   64'h0123_4567_89AB_CDEF, 32'h0000_1000, 32'h0000_1018);
      vecs[2] = mk(1'b0, 32'h0000_2000, 64'h0, 1, 1'b1, 5, 2, 3, 1'b1,
                   64'hA5A5_0000_0000_0010, 32'h0000_2000, 32'h0000_2008);
      vecs[3] = mk(1'b0, 32'hFFFF_FFF8, 64'h0, 1, 1'b1, 1, 0, 0, 1'b0,
                   64'h7777_0000_0000_0000, 32'hFFFF_FFF8, 32'h0000_0000);
      vecs[4] = mk(1'b0, 32'hFFFF_FFF8, 64'h0, 1, 1'b0, 0, 1, 1, 1'b0,
                   64'h1111_2222_3333_4444, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
      vecs[5] = mk(1'b0, 32'h0000_1007, 64'h0, 0, 1'b1, 0, 0, 0, 1'b0,
                   64'hFEED_FACE_0000_0001, 32'h0000_1000, 32'h0000_1000);
      vecs[6] = mk(1'b1, 32'h0000_4000, 64'hFFFF_0000_FFFF_0000, 2, 1'b0, 2, 0, 2, 1'b1,
                   64'h9999_0000_0000_0000, 32'h0000_4000, 32'h0000_4000);
      vecs[7] = mk(1'b0, 32'h0000_0000, 64'h0, 255, 1'b1, 0, 0, 0, 1'b0,
                   64'h0000_0000_0001_0000, 32'h0000_0000, 32'h0000_07F8);

      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_inc = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; cmd_len = '0;
      rsp_ready = 1'b0;
      mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_req", mem_bus.req, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_addr", mem_bus.addr, 0);
      chk("rst_wdata", mem_bus.wdata, 0);
      chk("rst_we", mem_bus.we, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_last", rsp_last, 0);
      chk("rst_err", rsp_err, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset asserted while beat 2 of 4 waits for rvalid
      rv = mk(1'b0, 32'h0000_3000, 64'h0, 3, 1'b1, 0, 0, 0, 1'b0,
              64'h3333_0000_0000_0000, 32'h0000_3000, 32'h0000_3018);
      issue(rv.cmd);
      do_beat(rv, 0, ok);
      wait_req(ok);
      chk("rstseq_addr_beat2", mem_bus.addr, 32'h0000_3008);
      mem_bus.gnt = 1'b1;
      @(negedge clk);
      mem_bus.gnt = 1'b0;
      chk("rstseq_in_wait", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstseq_req", mem_bus.req, 0);
      chk("rstseq_busy", busy, 0);
      chk("rstseq_rsp_valid", rsp_valid, 0);
      chk("rstseq_addr", mem_bus.addr, 0);
      chk("rstseq_rdata", rsp_rdata, 0);
      @(negedge clk);
      mem_bus.rvalid = 1'b1;
      mem_bus.rdata  = 64'hBAD;
      @(negedge clk);
      mem_bus.rvalid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstseq_ready_after", cmd_ready, 1);
      chk("rstseq_no_rsp", rsp_valid, 0);
      run_vec(vecs[0]);

`ifdef JTAG_MEM_TIMEOUT_EN
      begin
         int req_cycles;
         rv = mk(1'b0, 32'h0000_5000, 64'h0, 3, 1'b1, 0, 0, 0, 1'b0,
                 64'h0, 32'h0000_5000, 32'h0000_5018);
         issue(rv.cmd);
         req_cycles = 0;
         for (int i = 0; i < 40; i++) begin
            if (mem_bus.req !== 1'b1) break;
            req_cycles++;
            @(negedge clk);
         end
         chk("to_req_cycles", 64'(req_cycles), 16);
         chk("to_rsp_valid", rsp_valid, 1);
         chk("to_rsp_err", rsp_err, 1);
         chk("to_rsp_last", rsp_last, 1);
         chk("to_rsp_rdata", rsp_rdata, 0);
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         chk("to_idle", busy, 0);
         mem_bus.rvalid = 1'b1;
         mem_bus.rdata  = 64'hBAD;
         @(negedge clk);
         mem_bus.rvalid = 1'b0;
         @(negedge clk);
         chk("to_late_rvalid_ignored", rsp_valid, 0);
         chk("to_ready_after", cmd_ready, 1);
         run_vec(vecs[5]);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
